md_pad6: RTL and testbench



---
 rtl/md_pad_pkg.sv | 45 ++++
 rtl/md_pad_sync.sv | 27 ++
 rtl/md_pad6.sv | 102 ++++++++++
 tb/tb_md_pad6.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/md_pad_pkg.sv
// md_pad_pkg: shared constants and pad-data helper for the Mega Drive pad model.
package md_pad_pkg;

    localparam int unsigned BTN_W             = 12;
    localparam int unsigned PIN_W             = 7;
    localparam int unsigned TH_BIT            = 6;
    localparam int unsigned MD_TIMEOUT_CYCLES = 161061;

    // Button vector bit positions
    localparam int unsigned BTN_UP    = 0;
    localparam int unsigned BTN_DOWN  = 1;
    localparam int unsigned BTN_LEFT  = 2;
    localparam int unsigned BTN_RIGHT = 3;
    localparam int unsigned BTN_A     = 4;
    localparam int unsigned BTN_B     = 5;
    localparam int unsigned BTN_C     = 6;
    localparam int unsigned BTN_START = 7;
    localparam int unsigned BTN_Z     = 8;
    localparam int unsigned BTN_Y     = 9;
    localparam int unsigned BTN_X     = 10;
    localparam int unsigned BTN_MODE  = 11;

    // Active-low pin levels for bits 5..0 given TH, phase and pressed-high buttons.
    // six=0 gives the three-button pattern regardless of phase.
    function automatic logic [5:0] pad_lvl(input logic             th,
                                           input logic [1:0]       ph,
                                           input logic             six,
                                           input logic [BTN_W-1:0] b);
        logic [5:0] lvl;
        if (th) begin
            if (six && (ph == 2'd3))
                lvl = ~{b[BTN_C], b[BTN_B], b[BTN_MODE], b[BTN_X], b[BTN_Y], b[BTN_Z]};
            else
                lvl = ~{b[BTN_C], b[BTN_B], b[BTN_RIGHT], b[BTN_LEFT], b[BTN_DOWN], b[BTN_UP]};
        end else begin
            lvl = {~b[BTN_START], ~b[BTN_A], 2'b00, ~b[BTN_DOWN], ~b[BTN_UP]};
            if (six && (ph == 2'd3))
                lvl[3:0] = 4'b1111;
            else if (six && (ph == 2'd2))
                lvl[3:0] = 4'b0000;
        end
        return lvl;
    endfunction

endpackage

// File: rtl/md_pad_sync.sv
// md_pad_sync: 2-flop synchronizer for asynchronous level inputs.
module md_pad_sync #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;

    // Two back-to-back capture stages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/md_pad6.sv
// md_pad6: Mega Drive six-button pad emulation on one controller port.
// Build option: define MD_PAD6_EN for six-button behaviour; otherwise a
// three-button pad with phase tied to 0.
module md_pad6
    import md_pad_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = MD_TIMEOUT_CYCLES,
    parameter int unsigned TMR_W          = 18
) (
    input  logic             MCLK,
    input  logic             RESET,
    input  logic [PIN_W-1:0] P_o,
    input  logic [PIN_W-1:0] P_d,
    input  logic [BTN_W-1:0] btn,
    output logic [PIN_W-1:0] P_i,
    output logic [1:0]       phase
);

    logic [BTN_W-1:0] btn_s;
    logic             th_c;
    logic             th_q;
    logic             rise_c;
    logic [1:0]       phase_sel_c;
    logic             six_c;
    logic [PIN_W-1:0] padlvl_c;
    logic [PIN_W-1:0] p_i_d;
    logic [PIN_W-1:0] p_i_q;

    md_pad_sync #(.W(BTN_W)) u_btn_sync (
        .clk   (MCLK),
        .rst_n (RESET),
        .d_i   (btn),
        .q_o   (btn_s)
    );

    // TH is console-driven only when its direction bit says so; the pad pulls it up
    assign th_c   = P_d[TH_BIT] ? 1'b1 : P_o[TH_BIT];
    assign rise_c = th_c & ~th_q;

`ifdef MD_PAD6_EN
    logic [1:0]       phase_q;
    logic [1:0]       phase_d;
    logic [TMR_W-1:0] tmr_q;
    logic [TMR_W-1:0] tmr_d;
    logic             expire_c;

    // Phase/timeout next state; a rising edge takes priority over expiry
    always_comb begin
        phase_d  = phase_q;
        tmr_d    = tmr_q;
        expire_c = (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) && !rise_c;
        if (rise_c) begin
            phase_d = phase_q + 2'd1;
            tmr_d   = '0;
        end else begin
            if (tmr_q < TMR_W'(TIMEOUT_CYCLES))
                tmr_d = tmr_q + TMR_W'(1);
            if (expire_c)
                phase_d = 2'd0;
        end
    end

    // Phase and timeout registers; timer resets saturated (idle)
    always_ff @(posedge MCLK or negedge RESET) begin
        if (!RESET) begin
            phase_q <= 2'd0;
            tmr_q   <= TMR_W'(TIMEOUT_CYCLES);
        end else begin
            phase_q <= phase_d;
            tmr_q   <= tmr_d;
        end
    end

    assign phase_sel_c = phase_q;
    assign six_c       = 1'b1;
`else
    logic unused_cfg_c;

    assign unused_cfg_c = ^TMR_W'(TIMEOUT_CYCLES);
    assign phase_sel_c  = 2'd0;
    assign six_c        = 1'b0;
`endif

    // Pad levels and per-bit direction mux toward the I/O chip
    assign padlvl_c = {th_c, pad_lvl(th_c, phase_sel_c, six_c, btn_s)};
    assign p_i_d    = (P_d & padlvl_c) | (~P_d & P_o);

    // TH history and registered pin levels
    always_ff @(posedge MCLK or negedge RESET) begin
        if (!RESET) begin
            th_q  <= 1'b1;
            p_i_q <= 7'h7f;
        end else begin
            th_q  <= th_c;
            p_i_q <= p_i_d;
        end
    end

    assign P_i   = p_i_q;
    assign phase = phase_sel_c;

endmodule

// File: tb/tb_md_pad6.sv
// tb_md_pad6: directed checks of md_pad6 in either build configuration.
module tb_md_pad6;

    localparam int unsigned T = 100;
`ifdef MD_PAD6_EN
    localparam bit SIX = 1'b1;
`else
    localparam bit SIX = 1'b0;
`endif

    logic        MCLK = 1'b0;
    logic        RESET;
    logic [6:0]  P_o;
    logic [6:0]  P_d;
    logic [11:0] btn;
    logic [6:0]  P_i;
    logic [1:0]  phase;

    int total = 0;
    int bad   = 0;

    md_pad6 #(.TIMEOUT_CYCLES(T), .TMR_W(18)) dut (
        .MCLK  (MCLK),
        .RESET (RESET),
        .P_o   (P_o),
        .P_d   (P_d),
        .btn   (btn),
        .P_i   (P_i),
        .phase (phase)
    );

    always #5 MCLK = ~MCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge MCLK);
    endtask

    task automatic th_level(input logic v, input int n);
        P_o[6] = v;
        tick(n);
    endtask

    initial begin
        RESET = 1'b0;
        P_d   = 7'h40;
        P_o   = 7'h00;
        btn   = 12'h000;
        tick(2);
        chk("rst_pi", 32'(P_i), 32'h7f);
        chk("rst_ph", 32'(phase), 32'h0);

        // TH console-driven, pad drives bits 5..0; up+a pressed
        P_d = 7'h3f;
        P_o = 7'h40;
        btn = 12'h011;
        tick(1);
        RESET = 1'b1;
        tick(20);
        chk("hi0", 32'(P_i), 32'h7e);
        chk("hi0_ph", 32'(phase), 32'h0);

        for (int i = 0; i < 3; i++) begin
            th_level(1'b0, 20);
            chk("lo", 32'(P_i), (i == 2) ? (SIX ? 32'h20 : 32'h22) : 32'h22);
            if (i == 2) btn = 12'hC00;
            th_level(1'b1, 20);
            chk("hi", 32'(P_i), (i == 2) ? (SIX ? 32'h73 : 32'h7f) : 32'h7e);
            chk("hi_ph", 32'(phase), SIX ? 32'(i + 1) : 32'h0);
        end
        th_level(1'b0, 20);
        chk("lo4", 32'(P_i), SIX ? 32'h3f : 32'h33);
        th_level(1'b1, 20);
        chk("hi5", 32'(P_i), 32'h7f);
        chk("hi5_ph", 32'(phase), 32'h0);

        // Timeout after two pulses
        btn = 12'h011;
        th_level(1'b0, 20);
        th_level(1'b1, 20);
        th_level(1'b0, 20);
        P_o[6] = 1'b1;
        tick(T);
        chk("to_pre", 32'(phase), SIX ? 32'h2 : 32'h0);
        tick(1);
        chk("to_exp", 32'(phase), 32'h0);
        chk("to_hi", 32'(P_i), 32'h7e);
        th_level(1'b0, 20);
        chk("to_lo1", 32'(P_i), 32'h22);

        // Rising edge landing on the expiry cycle
        P_o[6] = 1'b1;
        tick(T - 1);
        chk("col_pre", 32'(phase), SIX ? 32'h1 : 32'h0);
        P_o[6] = 1'b0;
        tick(1);
        P_o[6] = 1'b1;
        tick(1);
        chk("col_ph", 32'(phase), SIX ? 32'h2 : 32'h0);
`ifdef MD_PAD6_EN
        chk("col_tmr", 32'(dut.tmr_q), 32'h0);
`endif
        tick(19);
        th_level(1'b0, 20);
        chk("col_lo", 32'(P_i), SIX ? 32'h20 : 32'h22);

        // Console-driven bits and direction mux
        P_o = 7'h2a;
        tick(1);
        chk("cons_pad", 32'(P_i), SIX ? 32'h20 : 32'h22);
        P_d = 7'h00;
        tick(1);
        chk("cons_all", 32'(P_i), 32'h2a);
        P_d = 7'h0f;
        P_o = 7'h15;
        tick(1);
        chk("cons_mix", 32'(P_i), SIX ? 32'h10 : 32'h12);
        P_d = 7'h40;
        tick(1);
        chk("th_pull", 32'(P_i), 32'h55);
        chk("th_pull_ph", 32'(phase), SIX ? 32'h3 : 32'h0);

        // Button latency of three clocks
        P_d = 7'h3f;
        P_o = 7'h40;
        tick(3);
        chk("btn_old", 32'(P_i), SIX ? 32'h7f : 32'h7e);
        btn = 12'h040;
        tick(2);
        chk("btn_lat2", 32'(P_i), SIX ? 32'h7f : 32'h7e);
        tick(1);
        chk("btn_lat3", 32'(P_i), 32'h5f);

        // Asynchronous reset mid-sequence
        #2 RESET = 1'b0;
        #1;
        chk("arst_pi", 32'(P_i), 32'h7f);
        chk("arst_ph", 32'(phase), 32'h0);
        tick(1);
        RESET = 1'b1;
        tick(2);
        th_level(1'b0, 2);
        th_level(1'b1, 1);
        chk("arst_rise", 32'(phase), SIX ? 32'h1 : 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
